// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the regfile_sb register file
//
// Contents:
//   REGFILE_DATA_W / REGFILE_ADDR_W : default register width / address width
//   reg_addr_t / reg_data_t         : address and data types at the default widths
//   ZERO_ADDR                       : address of the hardwired zero register
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback/issue bus of the regfile_sb register file
//
// Signals:
//   rd_addr   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD*DATA_W  read data, same order as rd_addr
//   rd_busy   NUM_RD         pending-write flag of each read port's register
//   we/waddr/wdata           writeback write port (clears busy)
//   iss_valid/iss_addr       issue of a destination register (sets busy)
//   any_busy                 OR of all registered busy bits
// Modports: slave = register file side, master = pipeline side.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     any_busy;

  modport slave (
    input  rd_addr, we, waddr, wdata, iss_valid, iss_addr,
    output rd_data, rd_busy, any_busy
  );

  modport master (
    output rd_addr, we, waddr, wdata, iss_valid, iss_addr,
    input  rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: stored vs forwarded data, zero-register mask
//
// Ports:
//   addr      in   ADDR_W  read address of this port
//   mem_data  in   DATA_W  stored register contents at addr
//   mem_busy  in   1       registered busy bit at addr
//   byp_hit   in   1       same-cycle writeback targets addr and may be forwarded
//   byp_data  in   DATA_W  writeback data to forward
//   iss_hit   in   1       same-cycle issue targets addr
//   data      out  DATA_W  read data
//   busy      out  1       busy flag seen by decode
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_busy,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              iss_hit,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));

  always_comb begin
    data = mem_data;
    busy = mem_busy;
    // A forwarded write retires the pending producer, unless a newer
    // producer issues to the same register in this very cycle.
    if (byp_hit) begin
      data = byp_data;
      busy = iss_hit;
    end
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with N async read ports, one write port and busy scoreboard
//
// Ports:
//   clk    in  1  clock, all state updates on the rising edge
//   reset  in  1  asynchronous active-low reset, clears data and busy bits
//   bus    regfile_sb_if.slave  read ports, writeback, issue and any_busy
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a same-cycle writeback is forwarded to
//                      matching read ports (data and busy); otherwise reads
//                      show registered state only.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int ADDR_W   = REGFILE_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              iss_ok;
  logic              zero_w;
  logic              zero_i;

  assign zero_w = (ZERO_REG != 0) && (bus.waddr == ADDR_W'(ZERO_ADDR));
  assign zero_i = (ZERO_REG != 0) && (bus.iss_addr == ADDR_W'(ZERO_ADDR));
  assign wr_ok  = bus.we && !zero_w;
  assign iss_ok = bus.iss_valid && !zero_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[bus.waddr]  <= bus.wdata;
        busy[bus.waddr] <= 1'b0;
      end
      // Issue is the newer producer, so it overrides a same-address clear.
      if (iss_ok) begin
        busy[bus.iss_addr] <= 1'b1;
      end
    end
  end

  assign bus.any_busy = |busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp_hit;
    logic              iss_hit;

    assign addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign iss_hit = bus.iss_valid && (bus.iss_addr == addr);
`ifdef REGFILE_BYPASS_EN
    // Gated by reset so nothing leaks through while the array is held clear.
    assign byp_hit = reset && bus.we && (bus.waddr == addr);
`else
    assign byp_hit = 1'b0;
`endif

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .addr     (addr),
      .mem_data (mem[addr]),
      .mem_busy (busy[addr]),
      .byp_hit  (byp_hit),
      .byp_data (bus.wdata),
      .iss_hit  (iss_hit),
      .data     (bus.rd_data[k*DATA_W +: DATA_W]),
      .busy     (bus.rd_busy[k])
    );
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with N asynchronous read ports, one synchronous write port and a per-register pending-write scoreboard (busy bits). It is the next-generation register file for the MIPS core and sits between decode and writeback. Decode uses it to read operands and detect RAW hazards. Issue marks a destination busy, and writeback clears busy while writing the data.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rd_addr  in  NUM_RD*ADDR_W  read addresses, flattened; port k is bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, flattened in the same order as rd_addr.
- rd_busy  out  NUM_RD  busy bit of each read port's register.
- we  in  1  writeback write enable.
- waddr  in  ADDR_W  writeback address.
- wdata  in  DATA_W  writeback data.
- iss_valid  in  1  an instruction is issuing with a destination register.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage is mem[0..2**ADDR_W-1] of DATA_W bits, plus a busy vector of the same depth.
- Reset (reset=0), asynchronous:
  - Every entry is cleared to 0, including the last entry.
  - The whole busy vector is cleared.
  - Outputs while in reset: rd_data=0, rd_busy=0, any_busy=0.
- Reads are combinational, with zero latency: rd_data[k] = mem[rd_addr[k]].
- Write: on the rising edge with we=1, mem[waddr] <= wdata and busy[waddr] <= 0.
- Issue: on the rising edge with iss_valid=1, busy[iss_addr] <= 1.
- Issue and write to the same address in the same cycle:
  - mem is written.
  - busy ends at 1, because the issue is a newer producer and takes priority.
- Issue and write to different addresses: both take effect independently.
- Write to a register that is not busy is legal; data is stored and busy stays 0.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Issue to address 0 is dropped.
  - rd_data for address 0 is 0 and rd_busy for address 0 is 0, regardless of bypass.
- rd_busy[k] = busy[rd_addr[k]], modified by bypass (see Optional Feature).
- any_busy is the combinational OR of the registered busy vector; it is not bypassed.
- Reset asserted mid-operation: pending issue/write in that cycle is lost and all state clears. The first legal update is the first rising edge after reset returns to 1.
- Addresses are full range; there is no out-of-range case.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding is enabled.
  - When we=1 and rd_addr[k]==waddr (and not the zero register), rd_data[k] = wdata in the same cycle.
  - In that case rd_busy[k] = 0, unless the same-cycle iss_valid targets the same address.
  - The purely combinational path from wdata to rd_data is accepted.
- Undefined: no forwarding.
  - rd_data and rd_busy reflect registered state only.
  - The new value and the cleared busy bit are visible from the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_DATA_W=32 and REGFILE_ADDR_W=5;
  - typedef reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits);
  - localparam ZERO_ADDR = '0.
- One natural sub-module: regfile_rdport, the per-port mux that selects stored versus bypassed data and masks the zero register. It is instantiated NUM_RD times in a generate loop. The scoreboard stays in the top.

Test Plan:
- Reset: write 0xDEADBEEF to regs 5 and 31, then pulse reset=0 → reads of regs 5 and 31 return 0, and any_busy=0 while reset=0 and after release.
- Basic R/W: we=1, waddr=7, wdata=0x12345678 at edge t → port0 and port1 addr=7 read 0x12345678 from t+ onward. Write to 0 → reads 0.
- Scoreboard: iss_valid, iss_addr=9 at t → rd_busy=1 for addr 9 and any_busy=1. Write to 9 at t+3 → busy=0 after that edge. Issue to 0 → never busy.
- Collision: busy[4]=1, then same cycle iss_addr=4 and waddr=4 with wdata=0xA5 → mem[4]=0xA5 and busy[4] remains 1.
- Bypass (REGFILE_BYPASS_EN defined): rd_addr=3, we=1, waddr=3, wdata=0x55 → rd_data=0x55 and rd_busy=0 in the same cycle.
- Without the macro, the same stimulus → the old value in the write cycle and 0x55 in the next cycle.
- Mid-operation reset: iss_valid to 12 and we to 13 in the same cycle that reset falls → after release, busy[12]=0 and mem[13]=0.
